// File: rtl/multi_cycle_ctr_if.sv
// Control bus between the multi-cycle main controller and the shared
// memory / ALU / register-file datapath.
interface multi_cycle_ctr_if;
    logic [5:0] op_code;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;

    modport master (
        input  op_code, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source
    );

    modport slave (
        output op_code, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source
    );
endinterface

// File: rtl/multi_cycle_ctr.sv
// Multi-cycle MIPS main controller: Moore FSM stepping each instruction
// through fetch, decode, execute, memory and writeback, with a memory-ready
// handshake, immediate-ALU support, illegal-opcode flag and retire counter.
module multi_cycle_ctr #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ENABLE_IMM    = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multi_cycle_ctr_if.master    bus,
    output logic                 illegal_op,
    output logic [CNT_W-1:0]     retired,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    stateT      stateQ, stateD;
    logic       rdy, isImm, illegalD, retireD;
    logic       pcWrite, pcWriteCond, irWrite, memWrite, regWrite;
    logic       iOrD, memRead, memToReg, regDst, aluSrcA;
    logic [1:0] aluSrcB, pcSource;
    logic [2:0] aluOp;

    // Without the handshake every memory access completes in one cycle.
    assign rdy   = bus.mem_ready || !MEM_HANDSHAKE;
    assign isImm = ENABLE_IMM && ((bus.op_code == OP_ADDI) ||
                                  (bus.op_code == OP_ANDI) ||
                                  (bus.op_code == OP_ORI));

    // State register, registered illegal-opcode pulse and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= FETCH;
            illegal_op <= 1'b0;
            retired    <= '0;
        end else begin
            stateQ     <= stateD;
            illegal_op <= illegalD;
            if (retireD)
                retired <= retired + CNT_W'(1);
        end
    end

    // Next-state logic and per-state Moore control outputs.
    always_comb begin
        stateD      = stateQ;
        illegalD    = 1'b0;
        retireD     = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iOrD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 3'b000;
        pcSource    = 2'b00;
        case (stateQ)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = rdy;
                pcWrite = rdy;
                if (rdy)
                    stateD = DECODE;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode decodes.
                aluSrcB = 2'b11;
                if (bus.op_code == OP_RTYPE)
                    stateD = R_EXEC;
                else if ((bus.op_code == OP_LW) || (bus.op_code == OP_SW))
                    stateD = MEM_ADDR;
                else if (bus.op_code == OP_BEQ)
                    stateD = BRANCH;
                else if (bus.op_code == OP_J)
                    stateD = JUMP;
                else if (isImm)
                    stateD = I_EXEC;
                else begin
                    stateD   = FETCH;
                    illegalD = 1'b1;
                end
            end
            MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                stateD  = (bus.op_code == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                memRead = 1'b1;
                iOrD    = 1'b1;
                if (rdy)
                    stateD = MEM_WB;
            end
            MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                stateD   = FETCH;
                retireD  = 1'b1;
            end
            MEM_WRITE: begin
                // Write request stays up until memory accepts it.
                memWrite = 1'b1;
                iOrD     = 1'b1;
                if (rdy) begin
                    stateD  = FETCH;
                    retireD = 1'b1;
                end
            end
            R_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 3'b010;
                stateD  = R_WB;
            end
            R_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
                stateD   = FETCH;
                retireD  = 1'b1;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 3'b001;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                stateD      = FETCH;
                retireD     = 1'b1;
            end
            JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
                stateD   = FETCH;
                retireD  = 1'b1;
            end
            I_EXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                if (bus.op_code == OP_ANDI)
                    aluOp = 3'b011;
                else if (bus.op_code == OP_ORI)
                    aluOp = 3'b100;
                else
                    aluOp = 3'b000;
                stateD = I_WB;
            end
            I_WB: begin
                regWrite = 1'b1;
                stateD   = FETCH;
                retireD  = 1'b1;
            end
            default: stateD = FETCH;
        endcase
    end

    // Architectural write enables are suppressed during the reset cycle.
    assign bus.pc_write      = pcWrite     && !reset;
    assign bus.pc_write_cond = pcWriteCond && !reset;
    assign bus.ir_write      = irWrite     && !reset;
    assign bus.reg_write     = regWrite    && !reset;
    assign bus.mem_write     = memWrite    && !reset;
    assign bus.i_or_d        = iOrD;
    assign bus.mem_read      = memRead;
    assign bus.mem_to_reg    = memToReg;
    assign bus.reg_dst       = regDst;
    assign bus.alu_src_a     = aluSrcA;
    assign bus.alu_src_b     = aluSrcB;
    assign bus.alu_op        = aluOp;
    assign bus.pc_source     = pcSource;
    assign state             = stateQ;

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Bench for multi_cycle_ctr: directed scenarios plus randomized instruction
// streams checked against a per-opcode state-path model.
module tb_multi_cycle_ctr;
    logic        clk = 1'b0;
    logic        reset;
    logic        illA, illB;
    logic [31:0] retA;
    logic [3:0]  retB;
    logic [3:0]  stA, stB;
    int          errors = 0;
    int          checks = 0;
    int          mPath[$];

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI = 6'b001101;

    multi_cycle_ctr_if ifA();
    multi_cycle_ctr_if ifB();

    multi_cycle_ctr dutA (
        .clk(clk), .reset(reset), .bus(ifA),
        .illegal_op(illA), .retired(retA), .state(stA)
    );

    multi_cycle_ctr #(.MEM_HANDSHAKE(1'b0), .ENABLE_IMM(1'b0), .CNT_W(4)) dutB (
        .clk(clk), .reset(reset), .bus(ifB),
        .illegal_op(illB), .retired(retB), .state(stB)
    );

    always #5 clk = ~clk;

    // Reference: the states an instruction visits from its FETCH onward;
    // returns whether the instruction retires.
    function automatic bit modelPath(input logic [5:0] op, input bit immOn);
        mPath = {};
        if (op == R)                    begin mPath = '{0, 1, 6, 7};     return 1'b1; end
        if (op == LW)                   begin mPath = '{0, 1, 2, 3, 4};  return 1'b1; end
        if (op == SW)                   begin mPath = '{0, 1, 2, 5};     return 1'b1; end
        if (op == BEQ)                  begin mPath = '{0, 1, 8};        return 1'b1; end
        if (op == J)                    begin mPath = '{0, 1, 9};        return 1'b1; end
        if (immOn && (op == ADDI || op == ANDI || op == ORI)) begin
            mPath = '{0, 1, 10, 11};
            return 1'b1;
        end
        mPath = '{0, 1};
        return 1'b0;
    endfunction

    // Leaves the bench at a negedge with reset released and both DUTs in FETCH.
    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        ifA.mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; ifA.mem_ready = 1'b1; ifB.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (ifA.pc_write !== 1'b0) begin errors++; $display("FAIL reset_pc_write got %b expected 0", ifA.pc_write); end
        checks++; if (ifA.ir_write !== 1'b0) begin errors++; $display("FAIL reset_ir_write got %b expected 0", ifA.ir_write); end
        checks++; if (ifB.ir_write !== 1'b0) begin errors++; $display("FAIL reset_ir_write_b got %b expected 0", ifB.ir_write); end
        @(negedge clk);
        reset = 1'b0; ifA.mem_ready = 1'b0;
        #1;
        checks++; if (stA !== 4'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", stA); end
        checks++; if (retA !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d expected 0", retA); end
        checks++; if (illA !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b expected 0", illA); end
        checks++; if (retB !== 4'd0) begin errors++; $display("FAIL reset_retired_b got %0d expected 0", retB); end
        checks++; if (ifA.mem_read !== 1'b1) begin errors++; $display("FAIL reset_fetch_mem_read got %b expected 1", ifA.mem_read); end
    endtask

    task automatic test_rtype();
        int expSt[$];
        expSt = '{0, 1, 6, 7, 0};
        doReset();
        foreach (expSt[i]) begin
            ifA.op_code = R; ifA.mem_ready = 1'b1;
            #1;
            checks++; if (stA !== 4'(expSt[i])) begin errors++; $display("FAIL rtype_state cyc%0d got %0d expected %0d", i, stA, expSt[i]); end
            checks++; if (ifA.reg_write !== (expSt[i] == 7)) begin errors++; $display("FAIL rtype_reg_write cyc%0d got %b", i, ifA.reg_write); end
            checks++; if (ifA.reg_dst !== (expSt[i] == 7)) begin errors++; $display("FAIL rtype_reg_dst cyc%0d got %b", i, ifA.reg_dst); end
            @(negedge clk);
        end
        checks++; if (retA !== 32'd1) begin errors++; $display("FAIL rtype_retired got %0d expected 1", retA); end
    endtask

    task automatic test_lw_wait();
        int expSt[$];
        bit rdys[$];
        expSt = '{0, 1, 2, 3, 3, 3, 4, 0};
        rdys  = '{1, 1, 1, 0, 0, 1, 1, 1};
        doReset();
        foreach (expSt[i]) begin
            ifA.op_code = LW; ifA.mem_ready = rdys[i];
            #1;
            checks++; if (stA !== 4'(expSt[i])) begin errors++; $display("FAIL lw_state cyc%0d got %0d expected %0d", i, stA, expSt[i]); end
            checks++; if (ifA.mem_to_reg !== (expSt[i] == 4)) begin errors++; $display("FAIL lw_mem_to_reg cyc%0d got %b", i, ifA.mem_to_reg); end
            @(negedge clk);
        end
        checks++; if (retA !== 32'd1) begin errors++; $display("FAIL lw_retired got %0d expected 1", retA); end
    endtask

    task automatic test_beq_j();
        int expSt[$];
        logic [5:0] ops[$];
        logic [1:0] expSrc;
        expSt = '{0, 1, 8, 0, 1, 9, 0};
        ops   = '{BEQ, BEQ, BEQ, J, J, J, J};
        doReset();
        foreach (expSt[i]) begin
            ifA.op_code = ops[i]; ifA.mem_ready = 1'b1;
            expSrc = (expSt[i] == 8) ? 2'b01 : (expSt[i] == 9) ? 2'b10 : 2'b00;
            #1;
            checks++; if (stA !== 4'(expSt[i])) begin errors++; $display("FAIL bj_state cyc%0d got %0d expected %0d", i, stA, expSt[i]); end
            checks++; if (ifA.pc_write_cond !== (expSt[i] == 8)) begin errors++; $display("FAIL bj_pc_write_cond cyc%0d got %b", i, ifA.pc_write_cond); end
            checks++; if (ifA.pc_source !== expSrc) begin errors++; $display("FAIL bj_pc_source cyc%0d got %b expected %b", i, ifA.pc_source, expSrc); end
            @(negedge clk);
        end
        checks++; if (retA !== 32'd2) begin errors++; $display("FAIL bj_retired got %0d expected 2", retA); end
    endtask

    task automatic test_ori_imm();
        int expSt[$];
        expSt = '{0, 1, 10, 11, 0};
        doReset();
        foreach (expSt[i]) begin
            ifA.op_code = ORI; ifA.mem_ready = 1'b1;
            #1;
            checks++; if (stA !== 4'(expSt[i])) begin errors++; $display("FAIL ori_state cyc%0d got %0d expected %0d", i, stA, expSt[i]); end
            checks++; if (ifA.alu_op !== ((expSt[i] == 10) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL ori_alu_op cyc%0d got %b", i, ifA.alu_op); end
            @(negedge clk);
        end
        checks++; if (retA !== 32'd1) begin errors++; $display("FAIL ori_retired got %0d expected 1", retA); end
    endtask

    task automatic test_sw_nohs();
        int expSt[$];
        int wrCnt;
        expSt = '{0, 1, 2, 5, 0};
        wrCnt = 0;
        doReset();
        foreach (expSt[i]) begin
            ifB.op_code = SW; ifB.mem_ready = 1'b0;
            #1;
            if (ifB.mem_write === 1'b1) wrCnt++;
            checks++; if (stB !== 4'(expSt[i])) begin errors++; $display("FAIL sw_nohs_state cyc%0d got %0d expected %0d", i, stB, expSt[i]); end
            @(negedge clk);
        end
        checks++; if (wrCnt != 1) begin errors++; $display("FAIL sw_nohs_write_cycles got %0d expected 1", wrCnt); end
        checks++; if (retB !== 4'd1) begin errors++; $display("FAIL sw_nohs_retired got %0d expected 1", retB); end
    endtask

    task automatic test_illegal();
        int expSt[$];
        bit expIll[$];
        logic [5:0] ops[$];
        expSt  = '{0, 1, 0, 1, 0};
        expIll = '{0, 0, 1, 0, 1};
        ops    = '{6'b111111, 6'b111111, ORI, ORI, ORI};
        doReset();
        foreach (expSt[i]) begin
            ifB.op_code = ops[i]; ifB.mem_ready = 1'b1;
            #1;
            checks++; if (stB !== 4'(expSt[i])) begin errors++; $display("FAIL illegal_state cyc%0d got %0d expected %0d", i, stB, expSt[i]); end
            checks++; if (illB !== expIll[i]) begin errors++; $display("FAIL illegal_pulse cyc%0d got %b expected %b", i, illB, expIll[i]); end
            @(negedge clk);
        end
        checks++; if (retB !== 4'd0) begin errors++; $display("FAIL illegal_retired got %0d expected 0", retB); end
    endtask

    task automatic test_reset_midwait();
        int expSt[$];
        logic [5:0] ops[$];
        bit rdys[$];
        expSt = '{0, 1, 6, 7, 0, 1, 2, 5, 5};
        ops   = '{R, R, R, R, SW, SW, SW, SW, SW};
        rdys  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        doReset();
        foreach (expSt[i]) begin
            ifA.op_code = ops[i]; ifA.mem_ready = rdys[i];
            #1;
            checks++; if (stA !== 4'(expSt[i])) begin errors++; $display("FAIL midwait_state cyc%0d got %0d expected %0d", i, stA, expSt[i]); end
            if (expSt[i] == 5) begin
                checks++; if (ifA.mem_write !== 1'b1) begin errors++; $display("FAIL midwait_mem_write_held cyc%0d got %b expected 1", i, ifA.mem_write); end
            end
            @(negedge clk);
        end
        checks++; if (retA !== 32'd1) begin errors++; $display("FAIL midwait_retired_before got %0d expected 1", retA); end
        reset = 1'b1;
        #1;
        checks++; if (ifA.mem_write !== 1'b0) begin errors++; $display("FAIL midwait_reset_mem_write got %b expected 0", ifA.mem_write); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (stA !== 4'd0) begin errors++; $display("FAIL midwait_reset_state got %0d expected 0", stA); end
        checks++; if (retA !== 32'd0) begin errors++; $display("FAIL midwait_reset_retired got %0d expected 0", retA); end
    endtask

    task automatic test_random();
        logic [5:0] legalOps[8];
        logic [5:0] op;
        bit legal, prevIll, mem;
        int expRet, st, w;
        legalOps = '{R, LW, SW, BEQ, J, ADDI, ANDI, ORI};
        expRet = 0; prevIll = 1'b0;
        doReset();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 8) op = legalOps[$urandom_range(0, 7)];
            else op = 6'($urandom);
            legal = modelPath(op, 1'b1);
            for (int k = 0; k < mPath.size(); k++) begin
                st  = mPath[k];
                mem = (st == 0) || (st == 3) || (st == 5);
                w   = mem ? int'($urandom_range(0, 2)) : 0;
                for (int c = 0; c <= w; c++) begin
                    ifA.op_code   = op;
                    ifA.mem_ready = mem ? (c == w) : 1'($urandom_range(0, 1));
                    #1;
                    checks++; if (stA !== 4'(st)) begin errors++; $display("FAIL rand_state instr%0d op%b got %0d expected %0d", n, op, stA, st); end
                    checks++; if (illA !== (st == 0 && k == 0 && c == 0 && prevIll)) begin errors++; $display("FAIL rand_illegal instr%0d got %b", n, illA); end
                    checks++; if (ifA.ir_write !== (st == 0 && ifA.mem_ready)) begin errors++; $display("FAIL rand_ir_write instr%0d got %b", n, ifA.ir_write); end
                    checks++; if (ifA.mem_write !== (st == 5)) begin errors++; $display("FAIL rand_mem_write instr%0d got %b", n, ifA.mem_write); end
                    checks++; if (ifA.reg_write !== (st == 4 || st == 7 || st == 11)) begin errors++; $display("FAIL rand_reg_write instr%0d got %b", n, ifA.reg_write); end
                    if (st == 0 && c == 0) begin
                        checks++; if (retA !== 32'(expRet)) begin errors++; $display("FAIL rand_retired instr%0d got %0d expected %0d", n, retA, expRet); end
                    end
                    @(negedge clk);
                end
            end
            if (legal) expRet++;
            prevIll = !legal;
        end
        ifA.mem_ready = 1'b0;
        #1;
        checks++; if (retA !== 32'(expRet)) begin errors++; $display("FAIL rand_retired_final got %0d expected %0d", retA, expRet); end
        checks++; if (illA !== prevIll) begin errors++; $display("FAIL rand_illegal_final got %b expected %b", illA, prevIll); end
    endtask

    task automatic test_wrap();
        logic [5:0] ops[5];
        logic [5:0] op;
        int expRet;
        bit legal;
        ops = '{R, LW, SW, BEQ, J};
        expRet = 0;
        doReset();
        for (int n = 0; n < 17; n++) begin
            op = ops[$urandom_range(0, 4)];
            legal = modelPath(op, 1'b0);
            for (int k = 0; k < mPath.size(); k++) begin
                ifB.op_code = op; ifB.mem_ready = 1'($urandom_range(0, 1));
                #1;
                checks++; if (stB !== 4'(mPath[k])) begin errors++; $display("FAIL wrap_state instr%0d got %0d expected %0d", n, stB, mPath[k]); end
                if (k == 0) begin
                    checks++; if (retB !== 4'(expRet % 16)) begin errors++; $display("FAIL wrap_retired instr%0d got %0d expected %0d", n, retB, expRet % 16); end
                end
                @(negedge clk);
            end
            if (legal) expRet++;
        end
        #1;
        checks++; if (retB !== 4'd1) begin errors++; $display("FAIL wrap_retired_final got %0d expected 1", retB); end
    endtask

    initial begin
        reset = 1'b1;
        ifA.op_code = R; ifA.mem_ready = 1'b0;
        ifB.op_code = R; ifB.mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq_j();
        test_ori_imm();
        test_sw_nohs();
        test_illegal();
        test_reset_midwait();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_cycle_ctr.md
Name: multi_cycle_ctr

Overview:
- Multi-cycle MIPS main controller: Moore FSM sequencing fetch, decode, execute, memory and writeback over several clocks.
- Replaces the single-cycle combinational main decoder when the datapath moves to a shared memory, shared ALU and an instruction register.
- Adds a memory-ready handshake, immediate-ALU instructions, illegal-opcode detection and a retired-instruction counter.

Parameters:
- MEM_HANDSHAKE, 1, 1: FETCH/MEM_READ/MEM_WRITE wait for mem_ready; 0: mem_ready ignored, treated as 1.
- ENABLE_IMM, 1, 1: addi(001000)/andi(001100)/ori(001101) supported; 0: these are illegal.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- op_code  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  0 = PC address, 1 = ALUOut address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback from MDR.
- reg_dst  out  1  1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- alu_op  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or.
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target.
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- retired  out  CNT_W  count of completed instructions.
- state  out  4  current state encoding, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
- Reset (synchronous): state=FETCH, retired=0, illegal_op=0.
- While reset is high, pc_write, pc_write_cond, ir_write, reg_write and mem_write are forced to 0.
- Outputs not listed for a state are 0.
- FETCH: mem_read=1, alu_src_b=01, alu_op=000; ir_write=pc_write=rdy, where rdy = mem_ready or (MEM_HANDSHAKE==0). Moves to DECODE when rdy, otherwise holds.
- DECODE: alu_src_b=11, alu_op=000 (branch target precompute). Next state by op_code:
  - 000000 -> R_EXEC
  - 100011 and 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - immediate ops -> I_EXEC if ENABLE_IMM
  - anything else -> FETCH with illegal_op=1 for one cycle; not retired.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Moves to MEM_WB when rdy, otherwise holds.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Moves to FETCH when rdy, otherwise holds with mem_write held at 1.
- R_EXEC: alu_src_a=1, alu_op=010 -> R_WB.
- R_WB: reg_write=1, reg_dst=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_op=001, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10; alu_op=000 for addi, 011 for andi, 100 for ori (decoded from op_code) -> I_WB.
- I_WB: reg_write=1, reg_dst=0 -> FETCH.
- Retirement: retired increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or I_WB. It wraps modulo 2^CNT_W. Illegal-opcode returns do not count.
- Latency with rdy=1 every cycle: lw 5 clocks, sw 4, R-type 4, imm 4, beq 3, j 3.
- Each wait cycle on mem_ready adds exactly one clock.
- Reset asserted in any state, including mid-wait, returns to FETCH on the next edge; no write enable is asserted during the reset cycle.
- op_code is not latched; the IR must hold it stable from DECODE until return to FETCH.

Test Plan:
- Reset, then R-type 000000 with mem_ready=1: state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; retired=1.
- lw 100011 with mem_ready low for 2 cycles in MEM_READ: sequence 0,1,2,3,3,3,4,0 (8 clocks); mem_to_reg=1 in state 4; retired=1.
- sw 101011 with MEM_HANDSHAKE=0 and mem_ready tied to 0: sequence 0,1,2,5,0; mem_write=1 for exactly one cycle.
- beq then j: sequence 0,1,8,0,1,9,0; pc_write_cond=1 in state 8 and pc_source=10 in state 9; retired=2.
- Opcode 111111, then ori 001101 with ENABLE_IMM=0: illegal_op pulses once per instruction, each returns to FETCH after DECODE, retired stays 0. With ENABLE_IMM=1, ori gives alu_op=100 in state 10.
- Assert reset while in MEM_WRITE waiting on mem_ready=0: mem_write=0 in the reset cycle, state=0 after the edge, retired=0; CNT_W=4 run of 17 instructions gives retired=1.
